i_mem_loader: RTL and testbench
===============================

I_MEM_LOADER -- requirements
Module: i_mem_loader

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 64, the number of 32-bit words in the writable instruction memory.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum idle cycles allowed between accepted bytes during a load.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a load; sampled only in IDLE.
REQ-007 SHALL have port num_words, input, 7, the words to load; sampled with start.
REQ-008 SHALL have port byte_valid, input, 1, the source byte-valid signal.
REQ-009 SHALL have port byte_in, input, 8, the source byte.
REQ-010 SHALL have port byte_ready, output, 1, the loader-ready signal; a byte is accepted when byte_valid and byte_ready are both high.
REQ-011 SHALL have port we, output, 1, the instruction-memory write enable.
REQ-012 SHALL have port wr_addr, output, 32, the word index, matching the word-indexed addressing of the instruction memory.
REQ-013 SHALL have port wr_data, output, 32, the assembled instruction word.
REQ-014 SHALL have port busy, output, 1, high while a load is in progress.
REQ-015 SHALL have port done, output, 1, a sticky flag for successful completion.
REQ-016 SHALL have port error, output, 1, a sticky flag for a rejected or aborted load.
REQ-017 SHALL have port cpu_hold, output, 1, which equals busy and holds the core in reset while memory is written.

Function
REQ-018 SHALL implement three states: IDLE, LOAD and WRITE.
REQ-019 SHALL, in IDLE with start high, go to LOAD if 1 <= num_words <= ROM_SIZE; it SHALL then clear done and error, and zero the word index, byte index and timeout counter.
REQ-020 SHALL, in IDLE with start high and num_words equal to 0 or greater than ROM_SIZE, stay in IDLE, set error, clear done, and write nothing.
REQ-021 SHALL assert byte_ready only in LOAD; byte_ready SHALL be 0 in IDLE and WRITE.
REQ-022 SHALL assemble bytes big-endian: the first accepted byte goes to bits 31:24 and the fourth to bits 7:0.
REQ-023 SHALL, on acceptance of the fourth byte, register the word into wr_data and go to WRITE on the next edge.
REQ-024 SHALL, in WRITE, hold we at 1 for exactly one cycle, with wr_addr equal to the current word index and wr_data stable.
REQ-025 SHALL, on leaving WRITE, go to IDLE and set done if wr_addr equals num_words-1; otherwise it SHALL increment the word index and return to LOAD.
REQ-026 SHALL make write latency exactly one cycle: the fourth-byte handshake at edge N gives we high in cycle N+1.
REQ-027 SHALL ignore start while not in IDLE, with no effect on state or flags.
REQ-028 SHALL, in LOAD, clear the timeout counter on each accepted byte and otherwise increment it each cycle.
REQ-029 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1 without an accepted byte, go to IDLE, set error, and discard the partial word with no write.
REQ-030 SHALL ignore byte_valid outside LOAD; no byte is consumed.
REQ-031 SHALL never exceed ROM_SIZE-1 on wr_addr; the word index SHALL not wrap.
REQ-032 SHALL drive we low in every state except WRITE.

Reset
REQ-033 SHALL, on reset assertion and independent of clock, go to IDLE, set we, byte_ready, busy, cpu_hold, done and error to 0, set wr_addr and wr_data to 0, and clear the byte index and timeout counter.
REQ-034 SHALL, on reset during LOAD or WRITE, abort the load with no further write; a write in progress SHALL end immediately.

Structure
REQ-035 SHALL put the state encoding (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2) and the ROM_SIZE default in a shared package or include file used with i_mem.
REQ-036 SHALL put the big-endian byte assembler (shift register plus byte counter) in the sub-module word_assembler; the FSM and counters stay in i_mem_loader.

Verification
REQ-037 SHALL check: start with num_words=2, then bytes 8C,01,00,04,AC,02,00,08 streamed back-to-back -> we pulses for word 0 with data 32'h8C010004, then for word 1 with data 32'hAC020008; done=1, busy=0.
REQ-038 SHALL check: start with num_words=0, and separately num_words=65 -> error=1, we never asserted, state stays IDLE.
REQ-039 SHALL check: byte_valid toggled randomly during a 1-word load -> word correct, we high exactly one cycle, byte_ready low during WRITE.
REQ-040 SHALL check: three bytes sent, then silence for 1024 cycles -> error=1, busy=0, no write.
REQ-041 SHALL check: reset asserted in the WRITE cycle of word 3 of 10 -> we drops immediately, all outputs at reset values, and a new start with num_words=1 succeeds.
REQ-042 SHALL check: start pulsed mid-load -> ignored; the original load completes with done=1 and the correct word count.

Source files
------------

// File: rtl/i_mem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader and the i_mem it writes.
package i_mem_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2
   } state_e;

   localparam int ROM_SIZE_DEFAULT = 64;
   localparam int TIMEOUT_DEFAULT  = 1024;
   localparam int NW_W             = 7;

   // A load request is legal only for 1..rom_size words.
   function automatic logic count_ok(input logic [NW_W-1:0] n, input int rom_size);
      return (n != '0) && (int'(n) <= rom_size);
   endfunction

endpackage

// File: rtl/i_mem_loader_if.sv
// Host-side byte stream, start request and instruction-memory write port of the loader.
interface i_mem_loader_if;
   import i_mem_loader_pkg::*;

   logic            start;
   logic [NW_W-1:0] num_words;
   logic            byte_valid;
   logic [7:0]      byte_in;
   logic            byte_ready;
   logic            we;
   logic [31:0]     wr_addr;
   logic [31:0]     wr_data;
   logic            busy;
   logic            done;
   logic            error;
   logic            cpu_hold;

   modport master (
      output start, num_words, byte_valid, byte_in,
      input  byte_ready, we, wr_addr, wr_data, busy, done, error, cpu_hold
   );

   modport slave (
      input  start, num_words, byte_valid, byte_in,
      output byte_ready, we, wr_addr, wr_data, busy, done, error, cpu_hold
   );

endinterface

// File: rtl/i_mem_loader_word_assembler.sv
// Big-endian byte-to-word packer; word_vld fires combinationally with the 4th accepted byte.
// No backpressure of its own: it consumes whenever byte_acc is high.
module word_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_acc,
   input  logic [7:0]  byte_in,
   output logic        word_vld,
   output logic [31:0] word_dat
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;

   assign word_vld = byte_acc && (cnt_q == 2'd3);
   assign word_dat = {shift_q, byte_in};

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clr) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (byte_acc) begin
         shift_d = {shift_q[15:0], byte_in};
         cnt_d   = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/i_mem_loader.sv
// Streams bytes into 32-bit words and writes them to i_mem; we follows the 4th byte by one cycle.
// byte_ready is high only in LOAD, so the source is stalled during WRITE and while idle.
module i_mem_loader
   import i_mem_loader_pkg::*;
#(
   parameter int ROM_SIZE       = ROM_SIZE_DEFAULT,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   i_mem_loader_if.slave bus
);

   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic [NW_W-1:0] num_words_q, num_words_d;
   logic [NW_W-1:0] word_idx_q, word_idx_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [31:0]     wr_data_q, wr_data_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic            byte_ready, we, busy;
   logic            byte_acc, asm_clr, word_vld;
   logic [31:0]     word_dat;

   assign byte_acc = bus.byte_valid && byte_ready;

   word_assembler u_asm (
      .clock    (clock),
      .reset    (reset),
      .clr      (asm_clr),
      .byte_acc (byte_acc),
      .byte_in  (bus.byte_in),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         num_words_q <= '0;
         word_idx_q  <= '0;
         to_cnt_q    <= '0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_words_q <= num_words_d;
         word_idx_q  <= word_idx_d;
         to_cnt_q    <= to_cnt_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      num_words_d = num_words_q;
      word_idx_d  = word_idx_q;
      to_cnt_d    = to_cnt_q;
      wr_data_d   = wr_data_q;
      done_d      = done_q;
      error_d     = error_q;
      asm_clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               done_d = 1'b0;
               if (count_ok(bus.num_words, ROM_SIZE)) begin
                  state_d     = LOAD;
                  num_words_d = bus.num_words;
                  word_idx_d  = '0;
                  to_cnt_d    = '0;
                  error_d     = 1'b0;
                  asm_clr     = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (word_vld) begin
               wr_data_d = word_dat;
               to_cnt_d  = '0;
               state_d   = WRITE;
            end else if (byte_acc) begin
               to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
               // Source went quiet mid-load: drop the partial word.
               state_d = IDLE;
               error_d = 1'b1;
               asm_clr = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         WRITE: begin
            if (word_idx_q == num_words_q - NW_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               word_idx_d = word_idx_q + NW_W'(1);
               to_cnt_d   = '0;
               state_d    = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      we         = 1'b0;
      busy       = 1'b0;
      case (state_q)
         LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         WRITE: begin
            we   = 1'b1;
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.byte_ready = byte_ready;
   assign bus.we         = we;
   assign bus.busy       = busy;
   assign bus.cpu_hold   = busy;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.wr_addr    = {{(32-NW_W){1'b0}}, word_idx_q};

endmodule

// File: tb/tb_i_mem_loader.sv
// Directed bench for i_mem_loader: normal loads, bad counts, timeout, reset in WRITE, stray start.
module tb_i_mem_loader;
   import i_mem_loader_pkg::*;

   localparam int BOUND = 2000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   i_mem_loader_if bus ();

   i_mem_loader #(.ROM_SIZE(64), .TIMEOUT_CYCLES(1024)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   int          we_cnt      = 0;
   int          we_run      = 0;
   int          we_run_max  = 0;
   int          rdy_in_write = 0;
   int          lat_bad     = 0;
   logic        prev_hs     = 1'b0;
   logic [31:0] addr_log[$];
   logic [31:0] data_log[$];

   always @(negedge clock) begin
      if (!reset && bus.we) begin
         we_cnt++;
         addr_log.push_back(bus.wr_addr);
         data_log.push_back(bus.wr_data);
         we_run++;
         if (we_run > we_run_max) we_run_max = we_run;
         if (bus.byte_ready) rdy_in_write++;
         if (!prev_hs) lat_bad++;
      end else begin
         we_run = 0;
      end
      prev_hs = bus.byte_valid && bus.byte_ready;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [6:0] n);
      bus.num_words = n;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      while (!bus.byte_ready && t < BOUND) begin
         tick();
         t++;
      end
      if (!bus.byte_ready) chk("byte_rdy_bound", 32'(bus.byte_ready), 32'd1);
      tick();
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      logic [31:0] v;
      v = w;
      for (int i = 3; i >= 0; i--) send_byte(v[i*8 +: 8]);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (bus.busy && t < BOUND) begin
         tick();
         t++;
      end
      if (bus.busy) chk("idle_bound", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"},   32'(bus.we), 0);
      chk({tag, "_rdy"},  32'(bus.byte_ready), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_hold"}, 32'(bus.cpu_hold), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_err"},  32'(bus.error), 0);
      chk({tag, "_addr"}, bus.wr_addr, 0);
      chk({tag, "_data"}, bus.wr_data, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [31:0] w10 [0:3];
      w10[0] = 32'h10A00F00;
      w10[1] = 32'h11B01F03;
      w10[2] = 32'h12C02F06;
      w10[3] = 32'h13D03F09;

      bus.start = 1'b0;
      bus.num_words = '0;
      bus.byte_valid = 1'b0;
      bus.byte_in = '0;

      // Reset state
      repeat (2) tick();
      chk_reset_outputs("rst");
      reset = 1'b0;
      tick();

      // Two-word back-to-back load
      base = we_cnt;
      do_start(7'd2);
      chk("l2_busy", 32'(bus.busy), 1);
      chk("l2_hold", 32'(bus.cpu_hold), 1);
      chk("l2_rdy",  32'(bus.byte_ready), 1);
      send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
      send_byte(8'hAC); send_byte(8'h02); send_byte(8'h00); send_byte(8'h08);
      wait_idle();
      chk("l2_wecnt", 32'(we_cnt - base), 2);
      chk("l2_a0", addr_log[base],   32'd0);
      chk("l2_d0", data_log[base],   32'h8C010004);
      chk("l2_a1", addr_log[base+1], 32'd1);
      chk("l2_d1", data_log[base+1], 32'hAC020008);
      chk("l2_done", 32'(bus.done), 1);
      chk("l2_busy_end", 32'(bus.busy), 0);
      chk("l2_err", 32'(bus.error), 0);

      // Rejected counts 0 and 65
      base = we_cnt;
      do_start(7'd0);
      chk("n0_err",  32'(bus.error), 1);
      chk("n0_done", 32'(bus.done), 0);
      chk("n0_busy", 32'(bus.busy), 0);
      do_start(7'd65);
      chk("n65_err",  32'(bus.error), 1);
      chk("n65_busy", 32'(bus.busy), 0);
      tick();
      chk("bad_wecnt", 32'(we_cnt - base), 0);

      // byte_valid in IDLE is not consumed; then random-gap single word
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'hFF;
      repeat (3) tick();
      chk("idle_rdy", 32'(bus.byte_ready), 0);
      bus.byte_valid = 1'b0;
      base = we_cnt;
      do_start(7'd1);
      chk("rnd_err_clr", 32'(bus.error), 0);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] rw;
         rw = 32'h12345678;
         repeat ($urandom_range(0, 3)) tick();
         send_byte(rw[(3-i)*8 +: 8]);
      end
      wait_idle();
      chk("rnd_wecnt", 32'(we_cnt - base), 1);
      chk("rnd_data", data_log[base], 32'h12345678);
      chk("rnd_addr", addr_log[base], 32'd0);
      chk("rnd_done", 32'(bus.done), 1);

      // Start pulsed mid-load is ignored
      base = we_cnt;
      do_start(7'd3);
      send_byte(8'hDE); send_byte(8'hAD);
      do_start(7'd1);
      chk("mid_busy", 32'(bus.busy), 1);
      send_byte(8'hBE); send_byte(8'hEF);
      send_word(32'h01020304);
      send_word(32'hA5A55A5A);
      wait_idle();
      chk("mid_wecnt", 32'(we_cnt - base), 3);
      chk("mid_d0", data_log[base],   32'hDEADBEEF);
      chk("mid_a2", addr_log[base+2], 32'd2);
      chk("mid_d2", data_log[base+2], 32'hA5A55A5A);
      chk("mid_done", 32'(bus.done), 1);

      // Timeout after three bytes: last cycle before expiry, then expiry
      base = we_cnt;
      do_start(7'd1);
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
      repeat (1023) tick();
      chk("to_pending", 32'(bus.busy), 1);
      tick();
      chk("to_busy", 32'(bus.busy), 0);
      chk("to_err",  32'(bus.error), 1);
      chk("to_done", 32'(bus.done), 0);
      chk("to_wecnt", 32'(we_cnt - base), 0);
      do_start(7'd1);
      send_word(32'h11223344);
      wait_idle();
      chk("to_next_data", data_log[base], 32'h11223344);
      chk("to_next_err", 32'(bus.error), 0);

      // Reset during the WRITE cycle of word 3 of 10
      base = we_cnt;
      do_start(7'd10);
      for (int i = 0; i < 4; i++) send_word(w10[i]);
      chk("rw_we",   32'(bus.we), 1);
      chk("rw_addr", bus.wr_addr, 32'd3);
      chk("rw_data", bus.wr_data, w10[3]);
      #1 reset = 1'b1;
      #1 chk_reset_outputs("rw");
      tick();
      reset = 1'b0;
      tick();
      chk("rw_wecnt", 32'(we_cnt - base), 3);
      chk("rw_a2", addr_log[base+2], 32'd2);
      base = we_cnt;
      do_start(7'd1);
      send_word(32'hCAFEF00D);
      wait_idle();
      chk("rw_new_cnt",  32'(we_cnt - base), 1);
      chk("rw_new_data", data_log[base], 32'hCAFEF00D);
      chk("rw_new_addr", addr_log[base], 32'd0);
      chk("rw_new_done", 32'(bus.done), 1);

      // Global write-pulse properties
      chk("we_one_cycle", 32'(we_run_max), 1);
      chk("rdy_in_write", 32'(rdy_in_write), 0);
      chk("we_latency",   32'(lat_bad), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
